// File: rtl/fetch_buffer.sv
// fetch_buffer
//
// Instruction fetch buffer sitting between the PC-generating fetch unit and
// decode. Each fetch address becomes an instruction-memory request
// (req/gnt, then in-order rvalid). Up to MAX_OUTSTANDING granted requests are
// tracked in a PC tag queue. Returned words are queued with their PCs in a
// DEPTH-entry FIFO that decode drains over valid/ready. A flush empties the
// FIFO and marks every in-flight response for discard.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - an accepted response reaching an empty FIFO is presented to
//               decode combinationally in the same cycle, and is not written
//               to the FIFO if decode takes it immediately.
//   undefined - every response goes through the FIFO (registered outputs).
//
// Ports
//   clk_i          clock, rising edge
//   reset_ni       asynchronous active-low reset
//   pc_i           fetch address
//   pc_valid_i     pc_i valid
//   pc_ready_o     address granted this cycle (fetch unit advances)
//   flush_i        redirect: discard queued and in-flight fetches
//   imem_req_o     memory request
//   imem_addr_o    word-aligned request address
//   imem_gnt_i     memory grant
//   imem_rvalid_i  response valid (in order)
//   imem_rdata_i   instruction word
//   instr_valid_o  head entry valid
//   instr_ready_i  decode accepts head entry
//   instr_o        head instruction
//   instr_pc_o     PC of head instruction
//   count_o        FIFO occupancy

module fetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [31:0]              pc_i,
  input  logic                     pc_valid_i,
  output logic                     pc_ready_o,
  input  logic                     flush_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT_L = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

  // FIFO storage and pointers
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // In-order PC tags for granted requests
  logic [31:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr_q, tag_wr_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic          credit;
  logic          grant;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          bypass_vis;
  logic          bypass_take;
  logic [31:0]   head_tag;

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  // Reserving FIFO space for every in-flight request makes overflow impossible.
  assign credit = ((SW'(count_q) + SW'(outstanding_q)) < DEPTH_S) &&
                  (outstanding_q < MAX_OUT_L);

  // reset_ni gates pc_valid_i so no request escapes while in reset.
  assign imem_req_o  = pc_valid_i & reset_ni & credit & ~flush_i;
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign grant       = imem_req_o & imem_gnt_i;
  assign pc_ready_o  = grant;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok     = imem_rvalid_i & (outstanding_q != '0);
  assign rsp_keep   = rsp_ok & (discard_q == '0) & ~flush_i;
  assign head_tag   = tag_mem_q[tag_rd_q];
  assign fifo_empty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_vis  = fifo_empty & rsp_keep;
  assign bypass_take = bypass_vis & instr_ready_i;
`else
  assign bypass_vis  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign fifo_push = rsp_keep & ~bypass_take;
  // Flush wins over a pop in the same cycle.
  assign fifo_pop  = ~fifo_empty & instr_ready_i & ~flush_i;

  assign instr_valid_o = ~fifo_empty | bypass_vis;
  assign instr_o       = bypass_vis ? imem_rdata_i : instr_mem_q[rd_ptr_q];
  assign instr_pc_o    = bypass_vis ? head_tag     : pc_mem_q[rd_ptr_q];
  assign count_o       = count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (grant) begin
      tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + 1'b1;
    end
    if (rsp_ok) begin
      tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + 1'b1;
    end
    outstanding_d = outstanding_q + OW'(grant) - OW'(rsp_ok);

    if (flush_i) begin
      // Everything still in flight after this cycle must be thrown away;
      // a response arriving right now is dropped directly.
      discard_d = outstanding_q - OW'(rsp_ok);
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (rsp_ok && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
      if (fifo_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // FIFO entries are cleared on reset so the head outputs read zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        instr_mem_q[gi] <= '0;
        pc_mem_q[gi]    <= '0;
      end else if (fifo_push && (wr_ptr_q == AW'(gi))) begin
        instr_mem_q[gi] <= imem_rdata_i;
        pc_mem_q[gi]    <= head_tag;
      end
    end
  end

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        tag_mem_q[gi] <= '0;
      end else if (grant && (tag_wr_q == TW'(gi))) begin
        tag_mem_q[gi] <= pc_i;
      end
    end
  end

  // Memory must never answer when nothing is outstanding.
  rvalid_without_request: assert property (
    @(posedge clk_i) disable iff (!reset_ni)
    !(imem_rvalid_i && (outstanding_q == '0))
  );

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  count;

  fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .pc_i          (pc),
    .pc_valid_i    (pc_valid),
    .pc_ready_o    (pc_ready),
    .flush_i       (flush),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-flight memory request (memory side) and expected decode output.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          killed;
  } pend_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt   = 0;      // model FIFO occupancy
  logic [31:0] pc_base = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]} + 32'h13;
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted decode transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h with nothing expected", instr_pc, instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr", instr, mon_e.data);
        check("instr_pc", instr_pc, mon_e.pc);
        $display("decode pc=%h instr=%h", instr_pc, instr);
      end
    end
  end

  // One clocked cycle per iteration; probabilities in percent.
  task automatic run_phase(input int ncyc, input int pv, input int pg, input int pr,
                           input int pf, input int prdy, input int plow);
    bit          do_rv, kept, exp_req, exp_valid, f, pop, byp, push;
    int          outs;
    logic [31:0] cur_pc;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      f      = roll(pf);
      cur_pc = pc_base | (roll(plow) ? 32'($urandom_range(0, 3)) : 32'h0);
      do_rv  = (pend_q.size() > 0) && roll(pr);
      pc_valid    = roll(pv);
      pc          = cur_pc;
      gnt         = roll(pg);
      flush       = f;
      instr_ready = roll(prdy);
      rvalid      = do_rv;
      rdata       = do_rv ? pend_q[0].data : $urandom;

      outs      = pend_q.size();
      exp_req   = pc_valid && (cnt + outs < DEPTH) && (outs < MAXO) && !f;
      kept      = do_rv && !pend_q[0].killed && !f;
      exp_valid = (cnt > 0) || (BYP && kept);
      if (kept) exp_q.push_back('{pend_q[0].pc, pend_q[0].data});
      if (f) exp_q.delete();

      #1;
      check("imem_req", 32'(req), 32'(exp_req));
      check("pc_ready", 32'(pc_ready), 32'(exp_req && gnt));
      check("imem_addr", addr, {cur_pc[31:2], 2'b00});
      check("count", 32'(count), 32'(cnt));
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));

      if (do_rv) void'(pend_q.pop_front());
      if (f) foreach (pend_q[i]) pend_q[i].killed = 1'b1;
      pop  = (cnt > 0) && instr_ready && !f;
      byp  = BYP && (cnt == 0) && kept && instr_ready;
      push = kept && !byp;
      cnt  = f ? 0 : cnt + int'(push) - int'(pop);
      if (exp_req && gnt) begin
        pend_q.push_back('{cur_pc, mem_word(cur_pc), 1'b0});
        pc_base = pc_base + 32'h4;
      end
      if (f) pc_base = {20'h0, 8'($urandom_range(0, 255)), 4'h0};
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    pc_valid = 1'b1;
    pc       = 32'h23;
    gnt      = 1'b1;
    flush    = 1'b0;
    rvalid   = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("rst_req", 32'(req), 32'h0);
    check("rst_pc_ready", 32'(pc_ready), 32'h0);
    check("rst_addr", addr, 32'h20);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_count", 32'(count), 32'h0);
    pend_q.delete();
    exp_q.delete();
    cnt = 0;
    pc_valid = 1'b0;
    gnt      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 32'h0; pc_valid = 1'b0; flush = 1'b0; gnt = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; instr_ready = 1'b0;
    do_reset();

    pc_base = 32'h0;
    run_phase(20, 100, 100, 100, 0, 100, 0);   // streaming
    run_phase(12, 100, 100, 100, 0, 0, 0);     // backpressure to full
    run_phase(10, 100, 100, 100, 0, 100, 0);   // drain and resume
    run_phase(8, 0, 0, 100, 0, 100, 0);        // empty out
    pc_base = 32'h20;
    run_phase(3, 100, 0, 100, 0, 100, 0);      // grant stall
    run_phase(4, 100, 100, 100, 0, 100, 0);
    run_phase(500, 80, 70, 60, 5, 70, 20);     // random mix
    do_reset();                                 // reset mid-operation
    run_phase(300, 90, 90, 70, 20, 60, 20);    // flush heavy
    run_phase(150, 70, 60, 50, 3, 40, 20);
    run_phase(20, 0, 0, 100, 0, 100, 0);       // final drain

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d instructions never delivered, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between the PC-generating fetch unit and decode. It turns each fetch address into an instruction-memory request (req/gnt, then rvalid), tracks up to `MAX_OUTSTANDING` in-flight requests, and queues the returned instruction words with their PCs in a `DEPTH`-entry FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect flush empties the FIFO and drops responses that are still in flight.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum granted requests awaiting rvalid; 1..DEPTH.

- `clk_i` in 1: clock, rising edge.
- `reset_ni` in 1: reset, asynchronous, active-low.
- `pc_i` in 32: fetch address from the fetch unit.
- `pc_valid_i` in 1: `pc_i` is valid.
- `pc_ready_o` out 1: address accepted (granted) this cycle; the fetch unit advances.
- `flush_i` in 1: redirect (taken branch, JAL or JALR); discard all queued and in-flight fetches.
- `imem_req_o` out 1: memory request.
- `imem_addr_o` out 32: word-aligned request address.
- `imem_gnt_i` in 1: memory grant.
- `imem_rvalid_i` in 1: response valid; responses return in order.
- `imem_rdata_i` in 32: instruction word.
- `instr_valid_o` out 1: head entry valid.
- `instr_ready_i` in 1: decode accepts the head entry.
- `instr_o` out 32: head instruction.
- `instr_pc_o` out 32: PC of the head instruction.
- `count_o` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation

- **Credit rule.** A request may issue only when `count + outstanding < DEPTH` and `outstanding < MAX_OUTSTANDING`. This guarantees FIFO overflow is impossible.
- **Request outputs.**
  - `imem_req_o = pc_valid_i & credit & ~flush_i`.
  - `imem_addr_o = {pc_i[31:2], 2'b00}`.
  - `pc_ready_o = imem_req_o & imem_gnt_i`.
- **On grant.** `pc_i` is pushed into an in-order PC tag queue of `MAX_OUTSTANDING` entries, and `outstanding` increments.
- **On rvalid.** The tag queue pops and `outstanding` decrements.
  - If `discard > 0`: the response is dropped and `discard` decrements.
  - Otherwise `{imem_rdata_i, tag}` is written to the FIFO.
- **Pop.** `instr_valid_o & instr_ready_i` pops the head.
- **Simultaneous grant + rvalid.** `outstanding` is unchanged. The tag queue pushes and pops in the same cycle.
- **Simultaneous push + pop.** Legal at any occupancy, including full; `count` is unchanged.
- **Flush.**
  - The FIFO empties next cycle: `count` goes to 0 and `instr_valid_o` to 0.
  - `discard` is set to `outstanding` minus 1 if an rvalid arrives in the flush cycle; that response is itself dropped.
  - No request issues in the flush cycle.
  - A pop in the flush cycle has no effect; flush wins.
- **Protocol errors.** rvalid with `outstanding == 0` is ignored; simulation asserts. Pointers wrap modulo DEPTH.
- **Reset mid-operation.** All state clears immediately. Late responses from pre-reset requests are the memory's responsibility and are not tracked.

## Timing

- **Reset values:**
  - `pc_ready_o=0`, `imem_req_o=0` (`pc_valid_i` is gated by reset).
  - `imem_addr_o` follows `pc_i` with the low two bits zero.
  - `instr_valid_o=0`, `instr_o=0`, `instr_pc_o=0`, `count_o=0`.
  - `outstanding`, `discard` and all pointers 0.
- **Request path.** `imem_req_o` and `pc_ready_o` are combinational from `pc_valid_i`, `imem_gnt_i`, `flush_i` and registered counters.
- **Latency.** rvalid is earliest one cycle after grant. Without bypass, the instruction is visible on `instr_o` the cycle after rvalid.
- **Throughput.** Sustains one instruction per cycle with single-cycle memory when `MAX_OUTSTANDING ≥ 2` and `DEPTH ≥ 2`.
- **Output stability.** `instr_o` and `instr_pc_o` are stable while `instr_valid_o & ~instr_ready_i`.

## Configuration

- **`FETCH_BYPASS_EN` defined:**
  - When the FIFO is empty, an rvalid is not discarded and no flush is present, the response drives `instr_valid_o`, `instr_o` and `instr_pc_o` combinationally in the same cycle.
  - If `instr_ready_i` is also high, the response is not written to the FIFO.
- **Undefined:**
  - All responses pass through the FIFO.
  - Outputs are purely registered, with a minimum of 1 cycle rvalid-to-output.

## Test plan

- **Reset, then streaming.** Release reset; present PCs 0x0,0x4,0x8 back-to-back with gnt=1 and rvalid one cycle after each grant; `instr_ready_i=1` -> decode sees 0x0,0x4,0x8 with matching `instr_pc_o` on consecutive cycles.
- **Backpressure.** DEPTH=4, MAX_OUTSTANDING=2, `instr_ready_i=0`, continuous PCs -> exactly 4 grants total, `count_o=4`, then `imem_req_o=0`. Raising ready drains all 4 in order, and requests resume.
- **Flush with in-flight requests.** Two requests granted (PCs 0x10, 0x14), then flush before their rvalid; new PC 0x100 issued the next cycle -> the 0x10/0x14 responses are dropped, and the first `instr_pc_o` is 0x100.
- **Flush coinciding with rvalid and pop.** FIFO holds 2 entries, 1 outstanding; flush, rvalid and ready in the same cycle -> next cycle `count_o=0`, `instr_valid_o=0`, discard=0, `outstanding=0`.
- **Grant stall.** `imem_gnt_i=0` for 3 cycles with `pc_valid_i=1`, `pc_i=0x20` -> `pc_ready_o=0` and `imem_req_o` held with `imem_addr_o=0x20`; grant on cycle 4 -> single push.
- **Bypass.** With `FETCH_BYPASS_EN`, FIFO empty, rvalid with rdata=0x00000013 and ready=1 -> `instr_valid_o=1` and `instr_o=0x00000013` in the same cycle, `count_o` stays 0. Without the macro, the instruction appears one cycle later.
